// File: rtl/rot_ctrl_if.sv
// rot_ctrl_if: bundles every non-clock signal of the image rotation controller.
//   Register-file side : start, soft_reset, mode, dir, img_h, img_w, src_img,
//                        dst_img, intr_mask, intr_clear (in);
//                        new_h, new_w, busy, bef_mask, aft_mask, intr (out).
//   DMA read side      : rd_req, rd_addr (out); rd_valid, rd_data (in).
//   DMA write side     : wr_req, wr_addr, wr_data (out); wr_ack (in).
// The master modport is the environment (register file + DMA) and the slave
// modport is the controller itself.
interface rot_ctrl_if;
  logic        start;
  logic        soft_reset;
  logic [1:0]  mode;
  logic        dir;
  logic [15:0] img_h;
  logic [15:0] img_w;
  logic [31:0] src_img;
  logic [31:0] dst_img;
  logic        intr_mask;
  logic        intr_clear;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_ack;
  logic [15:0] new_h;
  logic [15:0] new_w;
  logic        busy;
  logic        bef_mask;
  logic        aft_mask;
  logic        intr;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (
    output start, soft_reset, mode, dir, img_h, img_w, src_img, dst_img,
           intr_mask, intr_clear, rd_valid, rd_data, wr_ack,
    input  new_h, new_w, busy, bef_mask, aft_mask, intr,
           rd_req, rd_addr, wr_req, wr_addr, wr_data
  );

  modport slave (
    input  start, soft_reset, mode, dir, img_h, img_w, src_img, dst_img,
           intr_mask, intr_clear, rd_valid, rd_data, wr_ack,
    output new_h, new_w, busy, bef_mask, aft_mask, intr,
           rd_req, rd_addr, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/rot_ctrl.sv
// rot_ctrl: rotates an 8-bit image by 0/90/180/270 degrees, one pixel at a
// time. Each source pixel is read in row-major order through a single-beat
// DMA read, then written to its rotated position through a single-beat DMA
// write. Exactly one transfer is outstanding at any time.
//   clk : sole clock, rising edge.
//   rst : asynchronous active-high reset, clears all state.
//   bus : rot_ctrl_if.slave carrying configuration, status/interrupt and the
//         DMA read/write handshakes.
module rot_ctrl (
  input logic     clk,
  input logic     rst,
  rot_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    WRITE,
    NEXT,
    DONE
  } state_t;

  state_t      state;

  logic        start_q;
  logic        edge_armed;
  logic        start_edge;

  logic [1:0]  k;
  logic [15:0] cfg_h;
  logic [15:0] cfg_w;
  logic [31:0] cfg_src;
  logic [31:0] cfg_dst;

  logic [15:0] r_cnt;
  logic [15:0] c_cnt;
  logic [15:0] r_nxt;
  logic [15:0] c_nxt;
  logic        last_col;
  logic        last_row;

  logic [15:0] new_h;
  logic [15:0] new_w;
  logic        busy;
  logic        bef_mask;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;

  logic [31:0] h32;
  logic [31:0] w32;
  logic [31:0] r32;
  logic [31:0] c32;
  logic [31:0] wr_idx;
  logic [31:0] rd_idx_nxt;

  // edge_armed stays low for the first cycle after reset so that a START
  // level that was already high during reset is not mistaken for an edge.
  assign start_edge = bus.start & ~start_q & edge_armed;

  assign h32 = {16'd0, cfg_h};
  assign w32 = {16'd0, cfg_w};
  assign r32 = {16'd0, r_cnt};
  assign c32 = {16'd0, c_cnt};

  assign last_col = (c_cnt == cfg_w - 16'd1);
  assign last_row = (r_cnt == cfg_h - 16'd1);
  assign c_nxt    = last_col ? 16'd0 : c_cnt + 16'd1;
  assign r_nxt    = last_col ? r_cnt + 16'd1 : r_cnt;

  // Read index of the pixel that follows the current one; registered into
  // rd_addr when NEXT hands over to READ.
  assign rd_idx_nxt = {16'd0, r_nxt} * w32 + {16'd0, c_nxt};

  // Destination index of the current source pixel for each rotation.
  always_comb begin
    wr_idx = 32'd0;
    case (k)
      2'd0: wr_idx = r32 * w32 + c32;
      2'd1: wr_idx = c32 * h32 + (h32 - 32'd1 - r32);
      2'd2: wr_idx = (h32 - 32'd1 - r32) * w32 + (w32 - 32'd1 - c32);
      2'd3: wr_idx = (w32 - 32'd1 - c32) * h32 + r32;
      default: wr_idx = 32'd0;
    endcase
  end

  // Main controller: all outputs are registered here. Soft reset aborts the
  // job but deliberately keeps the reported rotated dimensions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      edge_armed <= 1'b0;
      k          <= 2'd0;
      cfg_h      <= 16'd0;
      cfg_w      <= 16'd0;
      cfg_src    <= 32'd0;
      cfg_dst    <= 32'd0;
      r_cnt      <= 16'd0;
      c_cnt      <= 16'd0;
      new_h      <= 16'd0;
      new_w      <= 16'd0;
      busy       <= 1'b0;
      bef_mask   <= 1'b0;
      rd_req     <= 1'b0;
      rd_addr    <= 32'd0;
      wr_req     <= 1'b0;
      wr_addr    <= 32'd0;
      wr_data    <= 8'd0;
    end else begin
      start_q    <= bus.start;
      edge_armed <= 1'b1;
      if (bus.soft_reset) begin
        state    <= IDLE;
        busy     <= 1'b0;
        rd_req   <= 1'b0;
        wr_req   <= 1'b0;
        r_cnt    <= 16'd0;
        c_cnt    <= 16'd0;
        bef_mask <= 1'b0;
      end else begin
        // Completion wins over a simultaneous clear.
        if (state == DONE) begin
          bef_mask <= 1'b1;
        end else if (bus.intr_clear) begin
          bef_mask <= 1'b0;
        end

        case (state)
          IDLE: begin
            if (start_edge) begin
              k       <= bus.dir ? (2'd0 - bus.mode) : bus.mode;
              cfg_h   <= bus.img_h;
              cfg_w   <= bus.img_w;
              cfg_src <= bus.src_img;
              cfg_dst <= bus.dst_img;
              busy    <= 1'b1;
              state   <= SETUP;
            end
          end
          SETUP: begin
            if (k[0]) begin
              new_h <= cfg_w;
              new_w <= cfg_h;
            end else begin
              new_h <= cfg_h;
              new_w <= cfg_w;
            end
            r_cnt <= 16'd0;
            c_cnt <= 16'd0;
            if ((cfg_h == 16'd0) || (cfg_w == 16'd0)) begin
              state <= DONE;
            end else begin
              rd_req  <= 1'b1;
              rd_addr <= cfg_src;
              state   <= READ;
            end
          end
          READ: begin
            if (bus.rd_valid) begin
              rd_req  <= 1'b0;
              wr_req  <= 1'b1;
              wr_addr <= cfg_dst + wr_idx;
              wr_data <= bus.rd_data;
              state   <= WRITE;
            end
          end
          WRITE: begin
            if (bus.wr_ack) begin
              wr_req <= 1'b0;
              state  <= NEXT;
            end
          end
          NEXT: begin
            if (last_col && last_row) begin
              state <= DONE;
            end else begin
              c_cnt   <= c_nxt;
              r_cnt   <= r_nxt;
              rd_req  <= 1'b1;
              rd_addr <= cfg_src + rd_idx_nxt;
              state   <= READ;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.new_h    = new_h;
  assign bus.new_w    = new_w;
  assign bus.busy     = busy;
  assign bus.bef_mask = bef_mask;
  assign bus.aft_mask = bef_mask & ~bus.intr_mask;
  assign bus.intr     = bef_mask & ~bus.intr_mask;
  assign bus.rd_req   = rd_req;
  assign bus.rd_addr  = rd_addr;
  assign bus.wr_req   = wr_req;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;

endmodule

// File: tb/tb_rot_ctrl.sv
// tb_rot_ctrl: directed bench for rot_ctrl. Stimulus pushes the expected read
// addresses and write address/data pairs into queues before each job; a
// monitor that also models the DMA pops and compares on every handshake.
module tb_rot_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rot_ctrl_if bus ();

  rot_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  int          checks = 0;
  int          errors = 0;
  int          rd_delay = 0;
  int          wr_delay = 0;
  int          rd_wait = 0;
  int          wr_wait = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  logic        rd_pend = 1'b0;
  logic        wr_pend = 1'b0;
  logic [31:0] rd_addr_prev = 32'd0;
  logic [31:0] wr_addr_prev = 32'd0;
  logic [7:0]  wr_data_prev = 8'd0;

  logic [31:0] rd_q[$];
  wr_exp_t     wr_q[$];
  logic [31:0] exp_wr[$];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // DMA model plus monitor: responds after the configured wait and checks
  // every completed transfer against the scoreboard queues.
  always @(negedge clk) begin
    wr_exp_t e;
    logic [31:0] a;
    if (rst) begin
      bus.rd_valid = 1'b0;
      bus.rd_data  = 8'd0;
      bus.wr_ack   = 1'b0;
      rd_wait = 0;
      wr_wait = 0;
      rd_pend = 1'b0;
      wr_pend = 1'b0;
    end else begin
      if (bus.rd_req) begin
        bus.rd_valid = (rd_wait >= rd_delay);
        bus.rd_data  = bus.rd_addr[7:0] ^ 8'h5A;
      end else begin
        bus.rd_valid = 1'b0;
      end
      if (bus.rd_req && !bus.rd_valid) rd_wait++;
      else rd_wait = 0;

      bus.wr_ack = bus.wr_req && (wr_wait >= wr_delay);
      if (bus.wr_req && !bus.wr_ack) wr_wait++;
      else wr_wait = 0;

      check_output("req_overlap", 32'(bus.rd_req & bus.wr_req), 32'd0);

      if (bus.rd_req && rd_pend)
        check_output("rd_addr_stable", bus.rd_addr, rd_addr_prev);
      if (bus.wr_req && wr_pend) begin
        check_output("wr_addr_stable", bus.wr_addr, wr_addr_prev);
        check_output("wr_data_stable", 32'(bus.wr_data), 32'(wr_data_prev));
      end

      if (bus.rd_req && bus.rd_valid) begin
        rd_count++;
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_read: got 0x%0h expected none", bus.rd_addr);
        end else begin
          a = rd_q.pop_front();
          check_output("rd_addr", bus.rd_addr, a);
        end
      end

      if (bus.wr_req && bus.wr_ack) begin
        wr_count++;
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got 0x%0h expected none", bus.wr_addr);
        end else begin
          e = wr_q.pop_front();
          check_output("wr_addr", bus.wr_addr, e.addr);
          check_output("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
      end

      rd_pend      = bus.rd_req && !bus.rd_valid;
      wr_pend      = bus.wr_req && !bus.wr_ack;
      rd_addr_prev = bus.rd_addr;
      wr_addr_prev = bus.wr_addr;
      wr_data_prev = bus.wr_data;
    end
  end

  // Queue the reads in row-major order and pair each with the hand-computed
  // destination address from exp_wr; write data is what the DMA model returns.
  task automatic expect_job(input logic [31:0] src, input logic [15:0] h,
                            input logic [15:0] w);
    int n;
    logic [31:0] a;
    wr_exp_t e;
    n = 0;
    for (int r = 0; r < int'(h); r++) begin
      for (int c = 0; c < int'(w); c++) begin
        a = src + 32'(r) * 32'(w) + 32'(c);
        rd_q.push_back(a);
        e.addr = exp_wr[n];
        e.data = a[7:0] ^ 8'h5A;
        wr_q.push_back(e);
        n++;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] mode, input logic dir,
                                input logic [15:0] h, input logic [15:0] w,
                                input logic [31:0] src, input logic [31:0] dst,
                                input logic hold_start);
    bus.mode    = mode;
    bus.dir     = dir;
    bus.img_h   = h;
    bus.img_w   = w;
    bus.src_img = src;
    bus.dst_img = dst;
    bus.start   = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 500) begin
      tick();
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got busy=1 expected busy=0", name);
    end
  endtask

  task automatic run_job(input string name, input logic [1:0] mode,
                         input logic dir, input logic [15:0] exp_nh,
                         input logic [15:0] exp_nw);
    int rd0;
    int wr0;
    rd0 = rd_count;
    wr0 = wr_count;
    expect_job(32'h100, 16'd2, 16'd3);
    apply_stimulus(mode, dir, 16'd2, 16'd3, 32'h100, 32'h200, 1'b0);
    check_output({name, "_busy"}, 32'(bus.busy), 32'd1);
    wait_idle(name);
    check_output({name, "_new_h"}, 32'(bus.new_h), 32'(exp_nh));
    check_output({name, "_new_w"}, 32'(bus.new_w), 32'(exp_nw));
    check_output({name, "_bef_mask"}, 32'(bus.bef_mask), 32'd1);
    check_output({name, "_reads"}, 32'(rd_count - rd0), 32'd6);
    check_output({name, "_writes"}, 32'(wr_count - wr0), 32'd6);
    check_output({name, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    check_output({name, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic clear_intr();
    bus.intr_clear = 1'b1;
    tick();
    bus.intr_clear = 1'b0;
    check_output("intr_cleared", 32'(bus.bef_mask), 32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int busy_cycles;
    int rd0;
    int wr0;
    int n;

    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.soft_reset = 1'b0;
    bus.mode       = 2'd0;
    bus.dir        = 1'b0;
    bus.img_h      = 16'd0;
    bus.img_w      = 16'd0;
    bus.src_img    = 32'd0;
    bus.dst_img    = 32'd0;
    bus.intr_mask  = 1'b0;
    bus.intr_clear = 1'b0;

    // Reset with START already high.
    tick();
    tick();
    rst = 1'b0;
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_rd_req", 32'(bus.rd_req), 32'd0);
    check_output("rst_wr_req", 32'(bus.wr_req), 32'd0);
    check_output("rst_new_h", 32'(bus.new_h), 32'd0);
    check_output("rst_new_w", 32'(bus.new_w), 32'd0);
    check_output("rst_bef_mask", 32'(bus.bef_mask), 32'd0);
    check_output("rst_intr", 32'(bus.intr), 32'd0);
    busy_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.busy) busy_cycles++;
    end
    check_output("start_high_after_rst", 32'(busy_cycles), 32'd0);
    bus.start = 1'b0;
    tick();

    // 90 degrees clockwise.
    exp_wr = '{32'h201, 32'h203, 32'h205, 32'h200, 32'h202, 32'h204};
    run_job("k1", 2'd1, 1'b0, 16'd3, 16'd2);
    check_output("k1_intr", 32'(bus.intr), 32'd1);
    check_output("k1_aft_mask", 32'(bus.aft_mask), 32'd1);
    clear_intr();

    // 90 degrees counter-clockwise is k=3.
    exp_wr = '{32'h204, 32'h202, 32'h200, 32'h205, 32'h203, 32'h201};
    run_job("k3", 2'd1, 1'b1, 16'd3, 16'd2);
    clear_intr();

    // 180 degrees.
    exp_wr = '{32'h205, 32'h204, 32'h203, 32'h202, 32'h201, 32'h200};
    run_job("k2", 2'd2, 1'b0, 16'd2, 16'd3);
    clear_intr();

    // Slow DMA; MODE=3 DIR=1 folds to k=1.
    rd_delay = 3;
    wr_delay = 2;
    exp_wr = '{32'h201, 32'h203, 32'h205, 32'h200, 32'h202, 32'h204};
    run_job("slow", 2'd3, 1'b1, 16'd3, 16'd2);
    rd_delay = 0;
    wr_delay = 0;
    clear_intr();

    // Empty image: straight through SETUP and DONE.
    rd0 = rd_count;
    apply_stimulus(2'd0, 1'b0, 16'd0, 16'd5, 32'h100, 32'h200, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy) busy_cycles++;
      tick();
    end
    check_output("empty_busy_cycles", 32'(busy_cycles), 32'd2);
    check_output("empty_reads", 32'(rd_count - rd0), 32'd0);
    check_output("empty_new_h", 32'(bus.new_h), 32'd0);
    check_output("empty_new_w", 32'(bus.new_w), 32'd5);
    check_output("empty_bef_mask", 32'(bus.bef_mask), 32'd1);
    bus.intr_mask = 1'b1;
    #1;
    check_output("masked_intr", 32'(bus.intr), 32'd0);
    check_output("masked_aft_mask", 32'(bus.aft_mask), 32'd0);
    check_output("masked_bef_mask", 32'(bus.bef_mask), 32'd1);
    bus.intr_mask = 1'b0;

    // Soft reset during the third pixel, with the interrupt still pending.
    exp_wr = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h205};
    expect_job(32'h100, 16'd2, 16'd3);
    wr0 = wr_count;
    apply_stimulus(2'd0, 1'b0, 16'd2, 16'd3, 32'h100, 32'h200, 1'b0);
    n = 0;
    while ((wr_count - wr0) < 2 && n < 200) begin
      tick();
      n++;
    end
    check_output("abort_reached_pixel3", 32'(wr_count - wr0), 32'd2);
    bus.soft_reset = 1'b1;
    tick();
    bus.soft_reset = 1'b0;
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    check_output("abort_rd_req", 32'(bus.rd_req), 32'd0);
    check_output("abort_wr_req", 32'(bus.wr_req), 32'd0);
    check_output("abort_bef_mask", 32'(bus.bef_mask), 32'd0);
    check_output("abort_new_h", 32'(bus.new_h), 32'd2);
    check_output("abort_new_w", 32'(bus.new_w), 32'd3);
    rd_q.delete();
    wr_q.delete();
    tick();
    check_output("abort_writes_stop", 32'(wr_count - wr0), 32'd2);
    exp_wr = '{32'h201, 32'h203, 32'h205, 32'h200, 32'h202, 32'h204};
    run_job("after_abort", 2'd1, 1'b0, 16'd3, 16'd2);

    // Clear held through DONE and START held across the end of the job.
    bus.intr_clear = 1'b1;
    exp_wr = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h205};
    expect_job(32'h100, 16'd2, 16'd3);
    apply_stimulus(2'd0, 1'b0, 16'd2, 16'd3, 32'h100, 32'h200, 1'b1);
    wait_idle("clear_on_done");
    bus.intr_clear = 1'b0;
    check_output("clear_on_done_bef_mask", 32'(bus.bef_mask), 32'd1);
    check_output("clear_on_done_wr_left", 32'(wr_q.size()), 32'd0);
    rd0 = rd_count;
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.busy) busy_cycles++;
    end
    check_output("held_start_no_rerun", 32'(busy_cycles), 32'd0);
    check_output("held_start_no_reads", 32'(rd_count - rd0), 32'd0);
    bus.start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
